inst_fetch_queue: RTL and testbench

//  Fetch queue plus IF/ID pipeline register between the PC/instruction-ROM fetch stage and the ID stage.
//  - Buffers DEPTH {pc, inst} pairs so that fetch can run ahead while ID is stalled.
//  - Presents one registered instruction per cycle to ID.
//  - Requests a PC stall from ctrl when full.
//  - Honours ctrl stall/flush and discards wrong-path fetches after a taken branch. The MIPS delay slot is kept.

---
 rtl/inst_fetch_queue_pkg.sv | 22 ++
 rtl/ifq_fifo.sv | 89 ++++++++
 rtl/inst_fetch_queue_defines.sv | 10 +
 rtl/inst_fetch_queue.sv | 122 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - entry type and output-select encoding for the fetch queue
`ifndef INST_FETCH_QUEUE_DEFINES_SV
`include "inst_fetch_queue_defines.sv"
`endif

package inst_fetch_queue_pkg;

    typedef struct packed {
        logic [`InstAddrBus] pc;
        logic [`InstBus]     inst;
    } ifq_entry_t;

    localparam ifq_entry_t IFQ_BUBBLE = '{pc: `ZeroWord, inst: `ZeroWord};

    typedef enum logic [1:0] {
        OUT_HOLD,
        OUT_BUBBLE,
        OUT_HEAD,
        OUT_BYPASS
    } ifq_out_sel_e;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - DEPTH-entry {pc,inst} circular buffer with clear and keep-head squash
`ifndef INST_FETCH_QUEUE_DEFINES_SV
`include "inst_fetch_queue_defines.sv"
`endif

module ifq_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic             keep_head,
    input  ifq_entry_t       wr_data,
    output ifq_entry_t       rd_data,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    ifq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok;
    logic              pop_ok;
    logic              squash;
    logic              wr_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign squash  = keep_head && !empty;
    assign wr_en   = push_ok && !clear && !squash;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (squash) begin
            // Younger entries are dropped by pulling the write pointer back to just past the head.
            wr_ptr_d = rd_ptr_q + PTR_W'(1);
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = '0;
            end else begin
                count_d  = (PTR_W+1)'(1);
            end
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstN_Enable) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetch_queue_defines.sv
// rtl/inst_fetch_queue_defines.sv - shared bus, reset and stall constants for the fetch path
`ifndef INST_FETCH_QUEUE_DEFINES_SV
`define INST_FETCH_QUEUE_DEFINES_SV
`define RstN_Enable 1'b0
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h00000000
`define NoStop      1'b0
`define Stop        1'b1
`endif

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch queue plus IF/ID register with stall/flush/branch squash
// Optional IFQ_BYPASS_EN: empty-queue fetches go straight to id_* when the output advances.
`ifndef INST_FETCH_QUEUE_DEFINES_SV
`include "inst_fetch_queue_defines.sv"
`endif

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic                branch_flag_i,
    input  logic                if_valid_i,
    input  logic [`InstAddrBus] if_pc_i,
    input  logic [`InstBus]     if_inst_i,
    output logic [`InstAddrBus] id_pc,
    output logic [`InstBus]     id_inst,
    output logic                id_valid,
    output logic                stallreq_o,
    output logic [PTR_W:0]      count_o
);

    ifq_entry_t    id_entry_q, id_entry_d;
    logic          id_valid_q, id_valid_d;
    ifq_entry_t    fetch_entry;
    ifq_entry_t    head_entry;
    ifq_out_sel_e  out_sel;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pushable;
    logic          pop;
    logic          bypass;
    logic          unused_stall;

    assign unused_stall = ^{stall[5:3], stall[0]};
    assign fetch_entry  = '{pc: if_pc_i, inst: if_inst_i};

    // Under a squash with a non-empty queue the head is the delay slot, so the fetch is wrong-path.
    assign pushable = if_valid_i && !fifo_full && !flush && (!branch_flag_i || fifo_empty);

    always_comb begin
        out_sel = OUT_BUBBLE;
        pop     = 1'b0;
        bypass  = 1'b0;
        if (flush) begin
            out_sel = OUT_BUBBLE;
        end else if (stall[1] == `Stop && stall[2] == `Stop) begin
            out_sel = OUT_HOLD;
        end else if (stall[1] == `Stop) begin
            out_sel = OUT_BUBBLE;
        end else if (!fifo_empty) begin
            out_sel = OUT_HEAD;
            pop     = 1'b1;
`ifdef IFQ_BYPASS_EN
        end else if (pushable) begin
            out_sel = OUT_BYPASS;
            bypass  = 1'b1;
`endif
        end
    end

    always_comb begin
        id_entry_d = id_entry_q;
        id_valid_d = id_valid_q;
        case (out_sel)
            OUT_HOLD: begin
                id_entry_d = id_entry_q;
                id_valid_d = id_valid_q;
            end
            OUT_HEAD: begin
                id_entry_d = head_entry;
                id_valid_d = 1'b1;
            end
            OUT_BYPASS: begin
                id_entry_d = fetch_entry;
                id_valid_d = 1'b1;
            end
            default: begin
                id_entry_d = IFQ_BUBBLE;
                id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstN_Enable) begin
            id_entry_q <= IFQ_BUBBLE;
            id_valid_q <= 1'b0;
        end else begin
            id_entry_q <= id_entry_d;
            id_valid_q <= id_valid_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pushable && !bypass),
        .pop       (pop),
        .clear     (flush),
        .keep_head (branch_flag_i && !flush),
        .wr_data   (fetch_entry),
        .rd_data   (head_entry),
        .count     (count_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign id_pc      = id_entry_q.pc;
    assign id_inst    = id_entry_q.inst;
    assign id_valid   = id_valid_q;
    assign stallreq_o = fifo_full;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized bench for inst_fetch_queue against a queue-level model
`timescale 1ns/1ps

module tb_inst_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PTR_W   = 2;
    localparam int N_CYC   = 3000;
    localparam int RST_CYC = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        branch_flag_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        stallreq_o;
    logic [PTR_W:0] count_o;

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_flag_i (branch_flag_i),
        .if_valid_i    (if_valid_i),
        .if_pc_i       (if_pc_i),
        .if_inst_i     (if_inst_i),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .stallreq_o    (stallreq_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic [31:0] fetch_pc;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        check_val({where, ".id_pc"},    64'(id_pc),      64'(m_pc));
        check_val({where, ".id_inst"},  64'(id_inst),    64'(m_inst));
        check_val({where, ".id_valid"}, 64'(id_valid),   64'(m_valid));
        check_val({where, ".count"},    64'(count_o),    64'(mq.size()));
        check_val({where, ".stallreq"}, 64'(stallreq_o), 64'(mq.size() == DEPTH));
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_inst  = 32'h0;
        m_valid = 1'b0;
    endtask

    // Applies the queue rules for the inputs currently driven; returns whether the fetch was taken.
    task automatic model_step(output bit taken);
        bit   was_empty;
        bit   can_take;
        bit   bypassed;
        ent_t f;
        f.pc      = if_pc_i;
        f.inst    = if_inst_i;
        was_empty = (mq.size() == 0);
        can_take  = if_valid_i && (mq.size() < DEPTH) && !flush && (!branch_flag_i || was_empty);
        bypassed  = 1'b0;
        if (flush) begin
            mq.delete();
            m_pc = 0; m_inst = 0; m_valid = 0;
            taken = 1'b0;
            return;
        end
        if (branch_flag_i && !was_empty) begin
            while (mq.size() > 1) void'(mq.pop_back());
        end
        if (stall[1] && stall[2]) begin
            // hold
        end else if (stall[1]) begin
            m_pc = 0; m_inst = 0; m_valid = 0;
        end else if (!was_empty) begin
            ent_t h;
            h = mq.pop_front();
            m_pc = h.pc; m_inst = h.inst; m_valid = 1;
        end else begin
`ifdef IFQ_BYPASS_EN
            if (can_take) begin
                m_pc = f.pc; m_inst = f.inst; m_valid = 1;
                bypassed = 1'b1;
            end else begin
                m_pc = 0; m_inst = 0; m_valid = 0;
            end
`else
            m_pc = 0; m_inst = 0; m_valid = 0;
`endif
        end
        if (can_take && !bypassed) mq.push_back(f);
        taken = can_take;
    endtask

    task automatic drive_random(input int cyc);
        int  phase;
        int  p_s1;
        int  p_s2;
        bit  s1;
        bit  s2;
        phase = (cyc / 64) % 4;
        case (phase)
            0: begin p_s1 = 5;  p_s2 = 50; end
            1: begin p_s1 = 80; p_s2 = 90; end
            2: begin p_s1 = 40; p_s2 = 50; end
            default: begin p_s1 = 50; p_s2 = 10; end
        endcase
        s1 = ($urandom_range(0, 99) < p_s1);
        s2 = s1 ? ($urandom_range(0, 99) < p_s2) : 1'($urandom_range(0, 1));
        stall         = {3'($urandom), s2, s1, 1'($urandom)};
        flush         = ($urandom_range(0, 99) < 3);
        branch_flag_i = ($urandom_range(0, 99) < 8);
        if_valid_i    = ($urandom_range(0, 99) < 80);
        if_pc_i       = fetch_pc;
        if_inst_i     = $urandom;
    endtask

    task automatic do_async_reset();
        @(posedge clk);
        #2;
        check_outputs("pre_rst");
        rst = 1'b0;
        #1;
        model_reset();
        check_val("async_rst.id_valid", 64'(id_valid), 64'h0);
        check_val("async_rst.count",    64'(count_o),  64'h0);
        check_outputs("async_rst");
        @(negedge clk);
        if_valid_i = 1'b1;
        stall      = 6'b0;
        @(negedge clk);
        check_outputs("in_rst");
        rst = 1'b1;
    endtask

    initial begin
        bit taken;
        rst           = 1'b0;
        stall         = 6'b0;
        flush         = 1'b0;
        branch_flag_i = 1'b0;
        if_valid_i    = 1'b0;
        if_pc_i       = 32'h0;
        if_inst_i     = 32'h0;
        fetch_pc      = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == RST_CYC) begin
                do_async_reset();
            end else begin
                @(negedge clk);
                check_outputs("run");
            end
            drive_random(cyc);
            model_step(taken);
            if (flush || branch_flag_i) begin
                fetch_pc = $urandom & 32'hFFFF_FFFC;
            end else if (taken) begin
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        @(negedge clk);
        check_outputs("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
